// File: rtl/arith_pkg.sv
// arith_pkg: op encodings, FSM states and counter sizing shared by seq_arith_unit
package arith_pkg;
   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_MUL = 2'b10;
   localparam logic [1:0] OP_DIV = 2'b11;
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
   function automatic int cnt_w(input int width);
      return $clog2(width + 1);
   endfunction
   localparam int CNT_W = cnt_w(8);
endpackage

// File: rtl/arith_iter_core.sv
// arith_iter_core: one shift-add (MUL) or restoring-subtract (DIV) step per cycle over {hi,lo}
module arith_iter_core
   import arith_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             is_div,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             done,
   output logic [WIDTH-1:0] hi_n,
   output logic [WIDTH-1:0] lo_n
);
   localparam int CW = cnt_w(WIDTH);
   logic [WIDTH-1:0] hi, lo, bq;
   logic dv;
   logic [CW-1:0] cnt;
   logic [WIDTH:0] sum, sh, dif;
   // hi_n/lo_n are the values after the current step, so the final step can be captured directly
   always_comb begin
      sum = {1'b0, hi} + (lo[0] ? {1'b0, bq} : '0);
      sh = {hi, lo[WIDTH-1]};
      dif = sh - {1'b0, bq};
      hi_n = dv ? (dif[WIDTH] ? sh[WIDTH-1:0] : dif[WIDTH-1:0]) : sum[WIDTH:1];
      lo_n = dv ? {lo[WIDTH-2:0], ~dif[WIDTH]} : {sum[0], lo[WIDTH-1:1]};
      done = cnt == CW'(1);
   end
   always_ff @(posedge clk)
      if (rst) cnt <= '0;
      else if (start) begin
         hi <= '0;
         lo <= a;
         bq <= b;
         dv <= is_div;
         cnt <= CW'(WIDTH);
      end else if (cnt != '0) begin
         hi <= hi_n;
         lo <= lo_n;
         cnt <= cnt - CW'(1);
      end
endmodule

// File: rtl/seq_arith_unit.sv
// seq_arith_unit: multi-cycle ADD/SUB/MUL/DIV with valid/ready handshakes
// ARITH_SAT_EN: saturate ADD/SUB/MUL results on overflow
module seq_arith_unit
   import arith_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [1:0]       op_sel,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] res_hi,
   output logic             overflow,
   output logic             div_by_zero
);
`ifdef ARITH_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif
   state_t state, nxt;
   logic [1:0] opr;
   logic acc, iter, done, fo, mo;
   logic [WIDTH-1:0] hi_n, lo_n, fr, fh;
   logic [WIDTH:0] sum, dif;
   assign acc = in_valid && in_ready;
   assign iter = op_sel == OP_MUL || (op_sel == OP_DIV && b != '0);
   arith_iter_core #(.WIDTH(WIDTH)) u_core (
      .clk    (clk),
      .rst    (rst),
      .start  (acc && iter),
      .is_div (op_sel == OP_DIV),
      .a      (a),
      .b      (b),
      .done   (done),
      .hi_n   (hi_n),
      .lo_n   (lo_n)
   );
   always_ff @(posedge clk)
      if (rst) state <= IDLE;
      else state <= nxt;
   always_comb begin
      nxt = state;
      case (state)
         IDLE: nxt = acc ? (iter ? BUSY : DONE) : IDLE;
         BUSY: nxt = done ? DONE : BUSY;
         DONE: nxt = out_ready ? IDLE : DONE;
         default: nxt = IDLE;
      endcase
   end
   always_comb begin
      in_ready = state == IDLE;
      out_valid = state == DONE;
   end
   // single-cycle path: ADD, SUB and DIV by zero
   always_comb begin
      sum = {1'b0, a} + {1'b0, b};
      dif = {1'b0, a} - {1'b0, b};
      fo = op_sel == OP_ADD ? sum[WIDTH] : op_sel == OP_SUB ? dif[WIDTH] : 1'b1;
      fr = op_sel == OP_ADD ? (SAT && fo ? '1 : sum[WIDTH-1:0]) :
           op_sel == OP_SUB ? (SAT && fo ? '0 : dif[WIDTH-1:0]) : '0;
      fh = op_sel == OP_DIV ? a : '0;
      mo = opr == OP_MUL && hi_n != '0;
   end
   always_ff @(posedge clk)
      if (rst) begin
         opr <= OP_ADD;
         result <= '0;
         res_hi <= '0;
         overflow <= 1'b0;
         div_by_zero <= 1'b0;
      end else if (acc) begin
         opr <= op_sel;
         if (!iter) begin
            result <= fr;
            res_hi <= fh;
            overflow <= fo;
            div_by_zero <= op_sel == OP_DIV;
         end
      end else if (state == BUSY && done) begin
         result <= SAT && mo ? '1 : lo_n;
         res_hi <= hi_n;
         overflow <= mo;
         div_by_zero <= 1'b0;
      end
endmodule

// File: tb/tb_seq_arith_unit.sv
// tb_seq_arith_unit: directed and random checks of seq_arith_unit against an arithmetic model
module tb_seq_arith_unit;
   logic clk = 1'b0;
   logic rst, in_valid, in_ready, out_valid, out_ready, overflow, div_by_zero;
   logic [7:0] a, b, result, res_hi;
   logic [1:0] op_sel;
   int nasserts = 0;
   int nfail = 0;
`ifdef ARITH_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   seq_arith_unit #(.WIDTH(8)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .a           (a),
      .b           (b),
      .op_sel      (op_sel),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .result      (result),
      .res_hi      (res_hi),
      .overflow    (overflow),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input int got, input int exp);
      nasserts++;
      assert (got === exp) else begin
         nfail++;
         $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // expected values from plain integer arithmetic
   task automatic model(input int op, input int x, input int y,
                        output int lo, output int hi, output int ov, output int dz, output int lat);
      int p;
      hi = 0; dz = 0; lat = 0;
      case (op)
         0: begin p = x + y; lo = p % 256; ov = int'(p > 255); if (SAT && ov == 1) lo = 255; end
         1: begin lo = (x - y + 256) % 256; ov = int'(x < y); if (SAT && ov == 1) lo = 0; end
         2: begin p = x * y; lo = p % 256; hi = p / 256; ov = int'(hi != 0); lat = 8;
                  if (SAT && ov == 1) lo = 255; end
         default: if (y == 0) begin lo = 0; hi = x; ov = 1; dz = 1; end
                  else begin lo = x / y; hi = x % y; ov = 0; lat = 8; end
      endcase
   endtask

   task automatic run(input string tag, input int op, input int x, input int y, input int hold);
      int lo, hi, ov, dz, lat, k, g;
      model(op, x, y, lo, hi, ov, dz, lat);
      g = 0;
      while (!in_ready && g < 50) begin tick(); g++; end
      chk({tag, " in_ready_idle"}, int'(in_ready), 1);
      op_sel = 2'(op); a = 8'(x); b = 8'(y); in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      k = 0;
      while (!out_valid && k < 40) begin
         chk({tag, " in_ready_busy"}, int'(in_ready), 0);
         tick();
         k++;
      end
      chk({tag, " latency"}, k, lat);
      chk({tag, " result"}, int'(result), lo);
      chk({tag, " res_hi"}, int'(res_hi), hi);
      chk({tag, " overflow"}, int'(overflow), ov);
      chk({tag, " div_by_zero"}, int'(div_by_zero), dz);
      for (int i = 0; i < hold; i++) begin
         in_valid = 1'b1; op_sel = 2'($urandom); a = 8'($urandom); b = 8'($urandom);
         tick();
         chk({tag, " hold_valid"}, int'(out_valid), 1);
         chk({tag, " hold_ready"}, int'(in_ready), 0);
         chk({tag, " hold_result"}, int'(result), lo);
         chk({tag, " hold_res_hi"}, int'(res_hi), hi);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk({tag, " release_valid"}, int'(out_valid), 0);
      chk({tag, " release_ready"}, int'(in_ready), 1);
      chk({tag, " kept_result"}, int'(result), lo);
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; op_sel = '0;
      tick(); tick();
      rst = 1'b0;
      chk("rst in_ready", int'(in_ready), 1);
      chk("rst out_valid", int'(out_valid), 0);
      chk("rst result", int'(result), 0);
      chk("rst res_hi", int'(res_hi), 0);
      chk("rst overflow", int'(overflow), 0);
      chk("rst div_by_zero", int'(div_by_zero), 0);
      run("add200+100", 0, 200, 100, 0);
      chk("add sat_value", int'(result), SAT ? 255 : 44);
      run("sub5-7", 1, 5, 7, 0);
      chk("sub sat_value", int'(result), SAT ? 0 : 254);
      run("mul15*17", 2, 15, 17, 0);
      run("mul16*16", 2, 16, 16, 0);
      run("div200/7", 3, 200, 7, 0);
      run("div9/0", 3, 9, 0, 0);
      run("bp_mul", 2, 13, 11, 5);
      // reset while MUL is in its third iteration
      op_sel = 2'd2; a = 8'd200; b = 8'd201; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick(); tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("midrst out_valid", int'(out_valid), 0);
      chk("midrst in_ready", int'(in_ready), 1);
      chk("midrst result", int'(result), 0);
      chk("midrst res_hi", int'(res_hi), 0);
      chk("midrst overflow", int'(overflow), 0);
      chk("midrst div_by_zero", int'(div_by_zero), 0);
      for (int i = 0; i < 12; i++) begin
         tick();
         chk("midrst no_emit", int'(out_valid), 0);
      end
      run("add1+1", 0, 1, 1, 0);
      chk("add1+1 value", int'(result), 2);
      for (int i = 0; i < 60; i++) begin
         int op, x, y;
         op = int'($urandom_range(0, 3));
         x = int'($urandom_range(0, 255));
         y = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(0, 255));
         run("rand", op, x, y, int'($urandom_range(0, 3)));
      end
      $display("End of test - %0d assertions evaluated, %0d failures", nasserts, nfail);
      $finish;
   end
endmodule

// File: doc/seq_arith_unit.md
Name: seq_arith_unit

Overview:
Parametrised, multi-cycle successor to the team's 4-bit combinational arithmetic unit. It supports ADD, SUB, MUL and DIV on WIDTH-bit unsigned operands. ADD and SUB complete in one cycle; MUL uses iterative shift-add and DIV uses iterative restoring division, giving full double-width product and remainder. It uses valid/ready handshakes on both sides and sits between the operand-issue logic and the result writeback stage.

Parameters:
WIDTH, 8, operand/result width in bits (>=2); MUL/DIV iteration count equals WIDTH

Ports:
clk  input  1  single clock, rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  operand/op presented
in_ready  output  1  unit can accept; high only in IDLE
a  input  WIDTH  operand A (unsigned)
b  input  WIDTH  operand B (unsigned)
op_sel  input  2  00 ADD, 01 SUB, 10 MUL, 11 DIV
out_valid  output  1  result available
out_ready  input  1  consumer accepts result
result  output  WIDTH  sum/difference/product low half/quotient
res_hi  output  WIDTH  MUL product high half; DIV remainder; 0 for ADD/SUB
overflow  output  1  carry (ADD), borrow (SUB), product >= 2^WIDTH (MUL), B==0 (DIV)
div_by_zero  output  1  DIV with b==0

Behaviour:
- Clocking: one clock, clk; reset rst is synchronous and active-high.
- Reset: state=IDLE. in_ready=1, out_valid=0. result, res_hi, overflow, div_by_zero all 0.
- Reset mid-operation: any in-flight op is aborted; nothing is emitted.
- Accept: a, b and op_sel are captured when in_valid && in_ready at a rising edge.
- States: IDLE -> (accept) BUSY or DONE; BUSY -> DONE after WIDTH iterations; DONE -> (out_ready) IDLE.
- ADD/SUB and DIV-by-zero: go straight to DONE. out_valid is high the cycle after accept (latency 1).
- MUL/DIV (b!=0): BUSY for WIDTH cycles, one bit per cycle. out_valid is high WIDTH+1 cycles after accept.
- ADD: {overflow,result} = a+b.
- SUB: result = (a-b) mod 2^WIDTH; overflow = (a<b).
- MUL: full 2*WIDTH-bit product; {res_hi,result} = a*b; overflow = (res_hi!=0).
- DIV, b!=0: result = a/b; res_hi = a%b; overflow=0; div_by_zero=0.
- DIV, b==0: result=0; res_hi=a; overflow=1; div_by_zero=1.
- Hold: while out_valid && !out_ready, all outputs stay stable and in_ready stays 0.
- Release: when out_valid && out_ready, the unit returns to IDLE. in_ready=1 next cycle; there is no same-cycle re-accept.
- Output registers: out_valid is deasserted on return to IDLE. The other outputs keep their last values until the next DONE.
- No combinational path from in_valid to in_ready, or from out_ready to out_valid.
- Unused op encodings: none; all four encodings are defined.

Optional Feature:
ARITH_SAT_EN:
- Defined: on overflow, ADD -> result all ones; SUB -> result 0; MUL -> result all ones (res_hi still the true high half). overflow is still asserted. DIV is unchanged.
- Undefined: wrap-around results as specified above.

Decomposition:
- Shared package arith_pkg:
  - op encoding constants OP_ADD=2'b00, OP_SUB=2'b01, OP_MUL=2'b10, OP_DIV=2'b11 (same encoding as the 4-bit unit);
  - state enum IDLE/BUSY/DONE;
  - localparam for the iteration-counter width, $clog2(WIDTH+1).
- One sub-module, arith_iter_core: shared shift register, accumulator and iteration counter performing one shift-add (MUL) or restore-subtract (DIV) step per cycle, with start/done ports. The top level holds the FSM, handshake, ADD/SUB and output registers.

Test Plan:
- All cases use WIDTH=8.
- ADD 200+100 -> out_valid 1 cycle after accept; result=44, overflow=1, res_hi=0. With ARITH_SAT_EN: result=255.
- SUB 5-7 -> result=254, overflow=1. With ARITH_SAT_EN: result=0.
- MUL 15*17 -> result=255, res_hi=0, overflow=0. MUL 16*16 -> result=0, res_hi=1, overflow=1. Both: out_valid exactly 9 cycles after accept, in_ready=0 throughout.
- DIV 200/7 -> result=28, res_hi=4, 9-cycle latency. DIV 9/0 -> result=0, res_hi=9, overflow=1, div_by_zero=1, 1-cycle latency.
- Backpressure: out_ready held low 5 cycles after out_valid -> outputs stable, in_ready=0, new in_valid ignored. Then out_ready=1 -> in_ready=1 next cycle.
- Reset asserted during MUL iteration 3 -> next cycle out_valid=0, in_ready=1, all outputs 0. A following ADD 1+1 returns result=2.
